rptr_ctrl_fwft: RTL and testbench

Parametrised read-side controller for the async FIFO.
- Maintains the binary read address and the Gray-coded read pointer.
- Generates registered empty and almost-empty flags, a fill level, and a sticky underflow error.
- Optionally presents data first-word-fall-through (FWFT) through a one-entry output register with a valid/ready handshake.
- Sits in the rclk domain between the FIFO memory (combinational read) and the write-pointer synchroniser.

---
 rtl/rptr_ctrl_fwft_if.sv | 34 +++
 rtl/rptr_ctrl_fwft.sv | 114 +++++++++++
 tb/tb_rptr_ctrl_fwft.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rptr_ctrl_fwft_if.sv
// rptr_ctrl_fwft_if: read-side FIFO controller bus (pop/accept controls, write-pointer
// and memory inputs, pointer/flag/level/data outputs). master = consumer side, slave = controller.
`default_nettype none

interface rptr_ctrl_fwft_if #(
  parameter int ADDR_LEN = 8,
  parameter int DATA_W   = 32
);
  logic                rincr_i;
  logic                rready_i;
  logic                rclr_err_i;
  logic [ADDR_LEN:0]   w2rptr_sync_i;
  logic [DATA_W-1:0]   rdata_mem_i;
  logic [ADDR_LEN-1:0] fifo_raddr_o;
  logic [ADDR_LEN:0]   rptr_o;
  logic                rempty_o;
  logic                raempty_o;
  logic [ADDR_LEN:0]   rlevel_o;
  logic [DATA_W-1:0]   rdata_o;
  logic                rvalid_o;
  logic                runderflow_o;

  modport master (
    output rincr_i, rready_i, rclr_err_i, w2rptr_sync_i, rdata_mem_i,
    input  fifo_raddr_o, rptr_o, rempty_o, raempty_o, rlevel_o, rdata_o, rvalid_o, runderflow_o
  );

  modport slave (
    input  rincr_i, rready_i, rclr_err_i, w2rptr_sync_i, rdata_mem_i,
    output fifo_raddr_o, rptr_o, rempty_o, raempty_o, rlevel_o, rdata_o, rvalid_o, runderflow_o
  );
endinterface

`default_nettype wire

// File: rtl/rptr_ctrl_fwft.sv
// rptr_ctrl_fwft: async-FIFO read-pointer controller with registered empty/almost-empty/level
// flags, sticky underflow and optional first-word-fall-through output register. Rev 1.0
`default_nettype none

module rptr_ctrl_fwft #(
  parameter int ADDR_LEN  = 8,
  parameter int DATA_W    = 32,
  parameter int AEMPTY_TH = 4,
  parameter int FWFT      = 0
) (
  input logic             rclk,
  input logic             rrst_n,
  rptr_ctrl_fwft_if.slave bus
);

  localparam int              PW          = ADDR_LEN + 1;
  localparam logic [PW-1:0]   c_aempty_th = PW'(AEMPTY_TH);

  logic [PW-1:0] r_rbin;
  logic [PW-1:0] r_rgray;
  logic [PW-1:0] r_rlevel;
  logic          r_rempty;
  logic          r_raempty;
  logic          r_runderflow;

  logic          w_pop;
  logic          w_rvalid;
  logic          w_underflow_set;
  logic [PW-1:0] w_rbin_next;
  logic [PW-1:0] w_rgray_next;
  logic [PW-1:0] w_wbin;
  logic [PW-1:0] w_level_next;

  // Gray-to-binary: bit i is the XOR of all Gray bits from i up to the MSB.
  always_comb begin
    w_wbin = '0;
    for (int i = 0; i < PW; i++) begin
      w_wbin[i] = ^(bus.w2rptr_sync_i >> i);
    end
  end

  always_comb begin
    if (FWFT != 0) begin
      w_pop           = !r_rempty && (!w_rvalid || bus.rready_i);
      w_underflow_set = bus.rready_i && !w_rvalid;
    end else begin
      w_pop           = bus.rincr_i && !r_rempty;
      w_underflow_set = bus.rincr_i && r_rempty;
    end
    w_rbin_next  = r_rbin + {{ADDR_LEN{1'b0}}, w_pop};
    w_rgray_next = (w_rbin_next >> 1) ^ w_rbin_next;
    w_level_next = w_wbin - w_rbin_next;
  end

  // Flags come from next-state pointers so they line up with the pointer update.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_rbin       <= '0;
      r_rgray      <= '0;
      r_rlevel     <= '0;
      r_rempty     <= 1'b1;
      r_raempty    <= 1'b1;
      r_runderflow <= 1'b0;
    end else begin
      r_rbin    <= w_rbin_next;
      r_rgray   <= w_rgray_next;
      r_rlevel  <= w_level_next;
      r_rempty  <= (w_rgray_next == bus.w2rptr_sync_i);
      r_raempty <= (w_level_next <= c_aempty_th);
      if (w_underflow_set) begin
        r_runderflow <= 1'b1;
      end else if (bus.rclr_err_i) begin
        r_runderflow <= 1'b0;
      end
    end
  end

  assign bus.fifo_raddr_o = r_rbin[ADDR_LEN-1:0];
  assign bus.rptr_o       = r_rgray;
  assign bus.rempty_o     = r_rempty;
  assign bus.raempty_o    = r_raempty;
  assign bus.rlevel_o     = r_rlevel;
  assign bus.runderflow_o = r_runderflow;

  generate
    if (FWFT != 0) begin : g_fwft
      logic              r_rvalid;
      logic [DATA_W-1:0] r_rdata;

      always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
          r_rvalid <= 1'b0;
          r_rdata  <= '0;
        end else if (w_pop) begin
          r_rvalid <= 1'b1;
          r_rdata  <= bus.rdata_mem_i;
        end else if (bus.rready_i && r_rvalid) begin
          r_rvalid <= 1'b0;
        end
      end

      assign w_rvalid     = r_rvalid;
      assign bus.rvalid_o = r_rvalid;
      assign bus.rdata_o  = r_rdata;
    end else begin : g_std
      assign w_rvalid     = !r_rempty;
      assign bus.rvalid_o = !r_rempty;
      assign bus.rdata_o  = bus.rdata_mem_i;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_rptr_ctrl_fwft.sv
// tb_rptr_ctrl_fwft: scoreboard bench driving a standard-pop and an FWFT instance (ADDR_LEN=3).
`default_nettype none

module tb_rptr_ctrl_fwft;
  logic rclk = 1'b0;
  logic rrst_n = 1'b0;
  always #5 rclk = ~rclk;

  rptr_ctrl_fwft_if #(.ADDR_LEN(3), .DATA_W(8)) b0 ();
  rptr_ctrl_fwft_if #(.ADDR_LEN(3), .DATA_W(8)) b1 ();

  rptr_ctrl_fwft #(.ADDR_LEN(3), .DATA_W(8), .AEMPTY_TH(4), .FWFT(0)) u_std (
    .rclk(rclk), .rrst_n(rrst_n), .bus(b0.slave));
  rptr_ctrl_fwft #(.ADDR_LEN(3), .DATA_W(8), .AEMPTY_TH(4), .FWFT(1)) u_fwft (
    .rclk(rclk), .rrst_n(rrst_n), .bus(b1.slave));

  logic [7:0] mem0 [8];
  logic [7:0] mem1 [8];
  assign b0.rdata_mem_i = mem0[b0.fifo_raddr_o];
  assign b1.rdata_mem_i = mem1[b1.fifo_raddr_o];

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [3:0] w0, r0, w1, r1;

  function automatic logic [3:0] gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic test_reset();
    logic [11:0] act0;
    logic [19:0] act1;
    rrst_n = 1'b0;
    b0.rincr_i = 0; b0.rready_i = 0; b0.rclr_err_i = 0; b0.w2rptr_sync_i = '0;
    b1.rincr_i = 0; b1.rready_i = 0; b1.rclr_err_i = 0; b1.w2rptr_sync_i = '0;
    w0 = 0; r0 = 0; w1 = 0; r1 = 0; q0.delete(); q1.delete();
    for (int i = 0; i < 8; i++) begin mem0[i] = 8'h00; mem1[i] = 8'h00; end
    tick(); tick();
    act0 = {b0.rempty_o, b0.raempty_o, b0.rlevel_o, b0.rptr_o, b0.rvalid_o, b0.runderflow_o};
    n_cmp++;
    if (act0 !== 12'b1_1_0000_0000_0_0) begin
      n_err++; $display("FAIL reset_std: got %b want %b", act0, 12'b1_1_0000_0000_0_0);
    end
    act1 = {b1.rempty_o, b1.raempty_o, b1.rlevel_o, b1.rptr_o, b1.rvalid_o, b1.runderflow_o, b1.rdata_o};
    n_cmp++;
    if (act1 !== 20'b1_1_0000_0000_0_0_00000000) begin
      n_err++; $display("FAIL reset_fwft: got %b want %b", act1, 20'b1_1_0000_0000_0_0_00000000);
    end
    rrst_n = 1'b1;
    tick();
    act0 = {b0.rempty_o, b0.raempty_o, b0.rlevel_o, b0.rptr_o, b0.rvalid_o, b0.runderflow_o};
    n_cmp++;
    if (act0 !== 12'b1_1_0000_0000_0_0) begin
      n_err++; $display("FAIL reset_release_std: got %b want %b", act0, 12'b1_1_0000_0000_0_0);
    end
  endtask

  task automatic test_std_pop();
    logic [10:0] act, exp;
    logic [7:0] d;
    for (int i = 0; i < 5; i++) begin
      mem0[i] = 8'hA0 + 8'(i);
      q0.push_back(8'hA0 + 8'(i));
    end
    w0 = 4'd5;
    b0.w2rptr_sync_i = gray(w0);
    tick();
    act = {b0.rempty_o, b0.raempty_o, b0.rlevel_o, b0.rptr_o, 1'b0};
    exp = {1'b0, 1'b0, 4'd5, 4'd0, 1'b0};
    n_cmp++;
    if (act !== exp) begin n_err++; $display("FAIL std_fill: got %b want %b", act, exp); end
    b0.rincr_i = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      d = q0.pop_front();
      n_cmp++;
      if (b0.rdata_o !== d) begin n_err++; $display("FAIL std_data[%0d]: got %h want %h", k, b0.rdata_o, d); end
      tick();
      r0 = r0 + 4'd1;
      act = {b0.rempty_o, b0.raempty_o, b0.rlevel_o, b0.rptr_o, b0.rvalid_o};
      exp = {(r0 == w0), ((w0 - r0) <= 4'd4), 4'(w0 - r0), gray(r0), (r0 != w0)};
      n_cmp++;
      if (act !== exp) begin n_err++; $display("FAIL std_pop[%0d]: got %b want %b", k, act, exp); end
    end
    b0.rincr_i = 1'b0;
  endtask

  task automatic test_wrap();
    int got = 0;
    int wr = 0;
    int cyc = 0;
    bit pop;
    logic [3:0] wseen;
    logic [3:0] lvl;
    logic [14:0] act, exp;
    logic [7:0] d;
    wseen = w0;
    while (got < 20 && cyc < 400) begin
      cyc++;
      if (wr < 20 && 4'(w0 - r0) < 4'd8 && ($urandom % 4) != 0) begin
        d = 8'($urandom);
        mem0[w0[2:0]] = d;
        q0.push_back(d);
        w0 = w0 + 4'd1;
        wr++;
        b0.w2rptr_sync_i = gray(w0);
      end
      pop = (r0 != wseen) && (($urandom % 3) != 0);
      b0.rincr_i = pop;
      if (pop) begin
        d = q0.pop_front();
        n_cmp++;
        if (b0.rdata_o !== d) begin n_err++; $display("FAIL wrap_data[%0d]: got %h want %h", got, b0.rdata_o, d); end
      end
      tick();
      if (pop) begin r0 = r0 + 4'd1; got++; end
      wseen = w0;
      lvl = w0 - r0;
      act = {b0.rempty_o, b0.raempty_o, b0.rlevel_o, b0.rptr_o, b0.fifo_raddr_o, b0.runderflow_o};
      exp = {(lvl == 4'd0), (lvl <= 4'd4), lvl, gray(r0), r0[2:0], 1'b0};
      n_cmp++;
      if (act !== exp || lvl > 4'd8) begin
        n_err++; $display("FAIL wrap_state[cyc %0d]: got %b want %b", cyc, act, exp);
      end
    end
    b0.rincr_i = 1'b0;
    n_cmp++;
    if (got < 20) begin n_err++; $display("FAIL wrap_timeout: got %0d words want 20", got); end
  endtask

  task automatic test_underflow();
    logic [4:0] act, exp;
    b0.rincr_i = 1'b1;
    tick();
    act = {b0.rptr_o, b0.runderflow_o}; exp = {gray(r0), 1'b1};
    n_cmp++;
    if (act !== exp) begin n_err++; $display("FAIL uf_set: got %b want %b", act, exp); end
    b0.rincr_i = 1'b0; b0.rclr_err_i = 1'b1;
    tick();
    n_cmp++;
    if (b0.runderflow_o !== 1'b0) begin n_err++; $display("FAIL uf_clear: got %b want 0", b0.runderflow_o); end
    b0.rincr_i = 1'b1;
    tick();
    act = {b0.rptr_o, b0.runderflow_o}; exp = {gray(r0), 1'b1};
    n_cmp++;
    if (act !== exp) begin n_err++; $display("FAIL uf_set_wins: got %b want %b", act, exp); end
    b0.rincr_i = 1'b0;
    tick();
    b0.rclr_err_i = 1'b0;
    n_cmp++;
    if (b0.runderflow_o !== 1'b0) begin n_err++; $display("FAIL uf_clear2: got %b want 0", b0.runderflow_o); end
    b1.rready_i = 1'b1;
    tick();
    act = {b1.rptr_o, b1.runderflow_o}; exp = {gray(r1), 1'b1};
    n_cmp++;
    if (act !== exp || b1.rvalid_o !== 1'b0) begin n_err++; $display("FAIL uf_fwft_set: got %b want %b", act, exp); end
    b1.rready_i = 1'b0; b1.rclr_err_i = 1'b1;
    tick();
    b1.rclr_err_i = 1'b0;
    n_cmp++;
    if (b1.runderflow_o !== 1'b0) begin n_err++; $display("FAIL uf_fwft_clear: got %b want 0", b1.runderflow_o); end
  endtask

  task automatic test_fwft();
    logic [14:0] act, exp;
    logic [7:0] d;
    for (int i = 0; i < 3; i++) begin
      mem1[w1[2:0]] = 8'h11 * 8'(i + 1);
      q1.push_back(8'h11 * 8'(i + 1));
      w1 = w1 + 4'd1;
    end
    b1.w2rptr_sync_i = gray(w1);
    b1.rready_i = 1'b0;
    tick();
    act = {b1.rvalid_o, 8'h00, b1.rempty_o, b1.rlevel_o, b1.runderflow_o};
    exp = {1'b0, 8'h00, 1'b0, 4'd3, 1'b0};
    n_cmp++;
    if (act !== exp) begin n_err++; $display("FAIL fwft_notyet: got %b want %b", act, exp); end
    tick();
    r1 = r1 + 4'd1;
    d = q1.pop_front();
    for (int k = 0; k <= 10; k++) begin
      act = {b1.rvalid_o, b1.rdata_o, b1.rempty_o, b1.rlevel_o, b1.runderflow_o};
      exp = {1'b1, d, 1'b0, 4'(w1 - r1), 1'b0};
      n_cmp++;
      if (act !== exp) begin n_err++; $display("FAIL fwft_hold[%0d]: got %b want %b", k, act, exp); end
      tick();
    end
    b1.rready_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      r1 = r1 + 4'd1;
      d = q1.pop_front();
      act = {b1.rvalid_o, b1.rdata_o, b1.rempty_o, b1.rlevel_o, b1.runderflow_o};
      exp = {1'b1, d, (r1 == w1), 4'(w1 - r1), 1'b0};
      n_cmp++;
      if (act !== exp) begin n_err++; $display("FAIL fwft_stream[%0d]: got %b want %b", k, act, exp); end
    end
    tick();
    act = {b1.rvalid_o, 8'h00, b1.rempty_o, b1.rlevel_o, b1.runderflow_o};
    exp = {1'b0, 8'h00, 1'b1, 4'd0, 1'b0};
    n_cmp++;
    if (act !== exp) begin n_err++; $display("FAIL fwft_drain: got %b want %b", act, exp); end
    b1.rready_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [10:0] act, exp;
    for (int i = 0; i < 3; i++) begin
      mem0[w0[2:0]] = 8'h50 + 8'(i); w0 = w0 + 4'd1;
      mem1[w1[2:0]] = 8'h60 + 8'(i); w1 = w1 + 4'd1;
    end
    b0.w2rptr_sync_i = gray(w0);
    b1.w2rptr_sync_i = gray(w1);
    tick();
    n_cmp++;
    if (b0.rlevel_o !== 4'd3) begin n_err++; $display("FAIL mid_level: got %0d want 3", b0.rlevel_o); end
    tick();
    act = {b1.rvalid_o, b1.rdata_o, 2'b00};
    exp = {1'b1, 8'h60, 2'b00};
    n_cmp++;
    if (act !== exp) begin n_err++; $display("FAIL mid_fwft_valid: got %b want %b", act, exp); end
    rrst_n = 1'b0;
    #1;
    act = {b0.rempty_o, b0.raempty_o, b0.rlevel_o, b0.rptr_o, b0.runderflow_o};
    exp = {1'b1, 1'b1, 4'd0, 4'd0, 1'b0};
    n_cmp++;
    if (act !== exp) begin n_err++; $display("FAIL mid_rst_std: got %b want %b", act, exp); end
    act = {b1.rvalid_o, b1.rdata_o, b1.rempty_o, 1'b0};
    exp = {1'b0, 8'h00, 1'b1, 1'b0};
    n_cmp++;
    if (act !== exp) begin n_err++; $display("FAIL mid_rst_fwft: got %b want %b", act, exp); end
    tick();
    n_cmp++;
    if ({b0.rptr_o, b1.rptr_o} !== 8'h00) begin
      n_err++; $display("FAIL mid_rst_edge: got %h want 00", {b0.rptr_o, b1.rptr_o});
    end
    b0.w2rptr_sync_i = '0; b1.w2rptr_sync_i = '0;
    w0 = 0; r0 = 0; w1 = 0; r1 = 0;
    rrst_n = 1'b1;
    tick();
    n_cmp++;
    if ({b0.rempty_o, b1.rempty_o, b1.rvalid_o} !== 3'b110) begin
      n_err++; $display("FAIL mid_rst_after: got %b want 110", {b0.rempty_o, b1.rempty_o, b1.rvalid_o});
    end
  endtask

  initial begin
    test_reset();
    test_std_pop();
    test_wrap();
    test_underflow();
    test_fwft();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule

`default_nettype wire
